pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised hazard controller for the five-stage pipelined CPU: generates PC/IF-ID enables, stage flushes/bubbles and EX-operand forwarding selects, and sequences a multi-cycle multiplier stall. It replaces the hard-wired always-enabled pipeline registers so that load-use, RAW, branch, jump and multiply hazards execute correctly. It also keeps saturating stall and flush counters for performance checks.

## Interface
Parameters:
- REG_AW, 5, register-number width
- MUL_LATENCY, 32, cycles a multiply occupies EX (>=1)
- FWD_EN, 1, 1 = forwarding from MEM/WB; 0 = no forwarding, stall on every RAW
- STAT_W, 16, width of the performance counters

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- rs_id, rt_id  in  REG_AW  source registers of the instruction in ID
- uses_rs_id, uses_rt_id  in  1  ID instruction actually reads rs / rt
- jump_id  in  1  jump decoded in ID
- rs_ex, rt_ex  in  REG_AW  source registers of the instruction in EX
- wn_ex, wn_mem, wn_wb  in  REG_AW  destination register in EX / MEM / WB
- regwrite_ex, regwrite_mem, regwrite_wb  in  1  stage writes the register file
- memread_ex  in  1  EX instruction is a load
- mul_ex  in  1  EX instruction is a multiply
- branch_taken_mem  in  1  branch resolved taken in MEM
- pc_en  out  1  PC load enable
- ifid_en  out  1  IF/ID enable
- ifid_flush, idex_bubble, exmem_bubble  out  1  zero the control fields entering that register
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 MEM ALU result, 01 WB data
- mul_busy  out  1  multiply hold active
- stall_cnt, flush_cnt  out  STAT_W  performance counters

## Operation
- Match rule: a stage "hits" register r when its regwrite=1, its wn!=0 and wn==r.
- Forwarding (FWD_EN=1): fwd_a=10 if MEM hits rs_ex, else 01 if WB hits rs_ex, else 00; fwd_b identically for rt_ex. MEM takes priority over WB. With FWD_EN=0, fwd_a=fwd_b=00 always.
- Load-use (FWD_EN=1): memread_ex and EX hits (uses_rs_id & rs_id) or (uses_rt_id & rt_id) -> pc_en=0, ifid_en=0, idex_bubble=1.
- RAW (FWD_EN=0): same stall response when EX, MEM or WB hits a used ID source.
- Multiply FSM, states RUN / MUL_WAIT with down-counter cnt:
  - RUN & mul_ex & MUL_LATENCY>1 -> hold this cycle, cnt<=MUL_LATENCY-2, go to MUL_WAIT.
  - MUL_WAIT & cnt!=0 -> hold, cnt<=cnt-1.
  - MUL_WAIT & cnt==0 -> release (no hold), go to RUN. A back-to-back multiply entering EX next cycle restarts the sequence.
  - hold = pc_en=0, ifid_en=0, ID/EX frozen (idex_bubble=0), exmem_bubble=1; mul_busy=hold.
  - MUL_LATENCY=1: the FSM never leaves RUN.
- Branch: branch_taken_mem -> ifid_flush=1, idex_bubble=1, exmem_bubble=1, pc_en=1. Aborts any multiply: state<=RUN, cnt<=0.
- Jump: jump_id with no higher-priority event -> ifid_flush=1.
- Priority: branch > multiply hold > load-use/RAW stall > jump. A jump suppressed by a stall is re-evaluated next cycle because it remains in ID.
- Counters, saturating at all-ones:
  - stall_cnt +1 for each cycle with pc_en=0.
  - flush_cnt +1 for each cycle with branch_taken_mem=1.

## Timing
- All hazard outputs are combinational from the inputs and the FSM state; FSM and counters update on the rising edge of clk.
- Reset (rst=0, asynchronous): state RUN, cnt 0, stall_cnt 0, flush_cnt 0. While rst=0 outputs are forced to pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, exmem_bubble=0, fwd_a=00, fwd_b=00, mul_busy=0.
- Reset asserted during MUL_WAIT aborts the multiply immediately. Release of rst begins in RUN.
- Multiply occupies EX for exactly MUL_LATENCY cycles and produces MUL_LATENCY-1 stall cycles.
- Load-use stall lasts exactly 1 cycle. With FWD_EN=0, a RAW stall lasts until the producer leaves WB: up to 3 cycles.
- Branch penalty: 3 flushed slots. Jump penalty: 1 slot.

## Test plan
- Load-use: lw wn_ex=5, memread_ex=1; ID add with rs_id=5 -> exactly 1 cycle pc_en=0, idex_bubble=1, stall_cnt=1; next cycle fwd_a=01.
- Forwarding priority: MEM and WB both hit rs_ex=7 -> fwd_a=10. wn_mem=0 with regwrite_mem=1 -> no forward (fwd_a=00).
- Multiply, MUL_LATENCY=4: mul_ex held -> mul_busy=1 for 3 cycles, exmem_bubble=1 on each, released on the 4th; stall_cnt=3. Repeat with MUL_LATENCY=1 -> no hold.
- Branch during multiply: branch_taken_mem=1 in the 2nd hold cycle -> three flush/bubble outputs high, pc_en=1, mul_busy=0 next cycle, flush_cnt=1.
- FWD_EN=0: add in MEM writing r3, ID reads r3 -> stall 2 cycles until the producer retires from WB; fwd_a=fwd_b=00 throughout.
- Async reset: drop rst mid-MUL_WAIT between clock edges -> mul_busy=0 and counters=0 immediately. Saturation: preload to all-ones -> stall_cnt stays all-ones on further stalls.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline. It produces the PC/IF-ID enables,
// the flush/bubble controls and the EX forwarding selects, and it sequences multiply holds.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MUL_LATENCY = 32,
    parameter int FWD_EN      = 1,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs_id,
    input  logic [REG_AW-1:0] rt_id,
    input  logic              uses_rs_id,
    input  logic              uses_rt_id,
    input  logic              jump_id,
    input  logic [REG_AW-1:0] rs_ex,
    input  logic [REG_AW-1:0] rt_ex,
    input  logic [REG_AW-1:0] wn_ex,
    input  logic [REG_AW-1:0] wn_mem,
    input  logic [REG_AW-1:0] wn_wb,
    input  logic              regwrite_ex,
    input  logic              regwrite_mem,
    input  logic              regwrite_wb,
    input  logic              memread_ex,
    input  logic              mul_ex,
    input  logic              branch_taken_mem,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mul_busy,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    // The down-counter only has to hold MUL_LATENCY-2.
    localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic              mul_hold;
    logic              load_use;
    logic              raw_stall;
    logic              pc_en_int;
    logic              ifid_en_int;
    logic              ifid_flush_int;
    logic              idex_bubble_int;
    logic              exmem_bubble_int;
    logic              mul_busy_int;

    function automatic logic hit(input logic rw, input logic [REG_AW-1:0] wn,
                                 input logic [REG_AW-1:0] r);
        return rw && (wn != '0) && (wn == r);
    endfunction

    // Index 0 is the rs operand and index 1 is the rt operand.
    logic [2*REG_AW-1:0] src_ex;
    logic [2*REG_AW-1:0] src_id;
    logic [1:0]          uses_id;
    logic [3:0]          fwd_all;
    logic [1:0]          ex_hit_id;
    logic [1:0]          mem_hit_id;
    logic [1:0]          wb_hit_id;

    assign src_ex  = {rt_ex, rs_ex};
    assign src_id  = {rt_id, rs_id};
    assign uses_id = {uses_rt_id, uses_rs_id};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            logic mem_fwd_hit;
            logic wb_fwd_hit;
            assign mem_fwd_hit = hit(regwrite_mem, wn_mem, src_ex[gi*REG_AW +: REG_AW]);
            assign wb_fwd_hit  = hit(regwrite_wb, wn_wb, src_ex[gi*REG_AW +: REG_AW]);
            assign fwd_all[gi*2 +: 2] = (FWD_EN == 0) ? 2'b00 :
                                        mem_fwd_hit   ? 2'b10 :
                                        wb_fwd_hit    ? 2'b01 : 2'b00;

            assign ex_hit_id[gi]  = uses_id[gi] &&
                                    hit(regwrite_ex, wn_ex, src_id[gi*REG_AW +: REG_AW]);
            assign mem_hit_id[gi] = uses_id[gi] &&
                                    hit(regwrite_mem, wn_mem, src_id[gi*REG_AW +: REG_AW]);
            assign wb_hit_id[gi]  = uses_id[gi] &&
                                    hit(regwrite_wb, wn_wb, src_id[gi*REG_AW +: REG_AW]);
        end
    endgenerate

    assign load_use  = (FWD_EN != 0) && memread_ex && (|ex_hit_id);
    assign raw_stall = (FWD_EN == 0) && (|(ex_hit_id | mem_hit_id | wb_hit_id));

    // Multiply sequencer: the first hold cycle comes from RUN, and the rest are counted down in MUL_WAIT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_hold = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mul_ex && (MUL_LATENCY > 1)) begin
                    mul_hold = 1'b1;
                    cnt_d    = CNT_W'(MUL_LATENCY - 2);
                    state_d  = ST_MUL_WAIT;
                end
            end
            ST_MUL_WAIT: begin
                if (cnt_q != '0) begin
                    mul_hold = 1'b1;
                    cnt_d    = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if (branch_taken_mem) begin
            state_d = ST_RUN;
            cnt_d   = '0;
        end
    end

    // The if-chain order sets the priority: branch > multiply hold > data stall > jump.
    always_comb begin
        pc_en_int        = 1'b1;
        ifid_en_int      = 1'b1;
        ifid_flush_int   = 1'b0;
        idex_bubble_int  = 1'b0;
        exmem_bubble_int = 1'b0;
        mul_busy_int     = 1'b0;
        if (branch_taken_mem) begin
            ifid_flush_int   = 1'b1;
            idex_bubble_int  = 1'b1;
            exmem_bubble_int = 1'b1;
        end else if (mul_hold) begin
            pc_en_int        = 1'b0;
            ifid_en_int      = 1'b0;
            exmem_bubble_int = 1'b1;
            mul_busy_int     = 1'b1;
        end else if (load_use || raw_stall) begin
            pc_en_int       = 1'b0;
            ifid_en_int     = 1'b0;
            idex_bubble_int = 1'b1;
        end else if (jump_id) begin
            ifid_flush_int = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_en_int && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        if (branch_taken_mem && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // While reset is held, the pipeline sees a plain free-running configuration.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_bubble = 1'b0;
        fwd_a        = 2'b00;
        fwd_b        = 2'b00;
        mul_busy     = 1'b0;
        if (rst) begin
            pc_en        = pc_en_int;
            ifid_en      = ifid_en_int;
            ifid_flush   = ifid_flush_int;
            idex_bubble  = idex_bubble_int;
            exmem_bubble = exmem_bubble_int;
            fwd_a        = fwd_all[1:0];
            fwd_b        = fwd_all[3:2];
            mul_busy     = mul_busy_int;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. It uses three instances: forwarding with a 4-cycle multiply,
// no forwarding with 2-bit counters, and a single-cycle multiply.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs_id, rt_id, rs_ex, rt_ex, wn_ex, wn_mem, wn_wb;
    logic       uses_rs_id, uses_rt_id, jump_id;
    logic       regwrite_ex, regwrite_mem, regwrite_wb;
    logic       memread_ex, mul_ex, branch_taken_mem;

    logic        m_pc_en, m_ifid_en, m_ifid_flush, m_idex_bubble, m_exmem_bubble, m_mul_busy;
    logic [1:0]  m_fwd_a, m_fwd_b;
    logic [15:0] m_stall_cnt, m_flush_cnt;
    logic        n_pc_en, n_ifid_en, n_ifid_flush, n_idex_bubble, n_exmem_bubble, n_mul_busy;
    logic [1:0]  n_fwd_a, n_fwd_b;
    logic [1:0]  n_stall_cnt, n_flush_cnt;
    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_bubble, s_exmem_bubble, s_mul_busy;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [15:0] s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LATENCY(4), .FWD_EN(1), .STAT_W(16)) u_main (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .uses_rs_id(uses_rs_id),
        .uses_rt_id(uses_rt_id), .jump_id(jump_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .wn_ex(wn_ex), .wn_mem(wn_mem), .wn_wb(wn_wb), .regwrite_ex(regwrite_ex),
        .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .memread_ex(memread_ex),
        .mul_ex(mul_ex), .branch_taken_mem(branch_taken_mem), .pc_en(m_pc_en),
        .ifid_en(m_ifid_en), .ifid_flush(m_ifid_flush), .idex_bubble(m_idex_bubble),
        .exmem_bubble(m_exmem_bubble), .fwd_a(m_fwd_a), .fwd_b(m_fwd_b),
        .mul_busy(m_mul_busy), .stall_cnt(m_stall_cnt), .flush_cnt(m_flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LATENCY(4), .FWD_EN(0), .STAT_W(2)) u_nofwd (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .uses_rs_id(uses_rs_id),
        .uses_rt_id(uses_rt_id), .jump_id(jump_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .wn_ex(wn_ex), .wn_mem(wn_mem), .wn_wb(wn_wb), .regwrite_ex(regwrite_ex),
        .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .memread_ex(memread_ex),
        .mul_ex(mul_ex), .branch_taken_mem(branch_taken_mem), .pc_en(n_pc_en),
        .ifid_en(n_ifid_en), .ifid_flush(n_ifid_flush), .idex_bubble(n_idex_bubble),
        .exmem_bubble(n_exmem_bubble), .fwd_a(n_fwd_a), .fwd_b(n_fwd_b),
        .mul_busy(n_mul_busy), .stall_cnt(n_stall_cnt), .flush_cnt(n_flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .MUL_LATENCY(1), .FWD_EN(1), .STAT_W(16)) u_lat1 (
        .clk(clk), .rst(rst), .rs_id(rs_id), .rt_id(rt_id), .uses_rs_id(uses_rs_id),
        .uses_rt_id(uses_rt_id), .jump_id(jump_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .wn_ex(wn_ex), .wn_mem(wn_mem), .wn_wb(wn_wb), .regwrite_ex(regwrite_ex),
        .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb), .memread_ex(memread_ex),
        .mul_ex(mul_ex), .branch_taken_mem(branch_taken_mem), .pc_en(s_pc_en),
        .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble),
        .exmem_bubble(s_exmem_bubble), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .mul_busy(s_mul_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        int rs_id, rt_id, uses_rs, uses_rt, jump;
        int rs_ex, rt_ex, wn_ex, wn_mem, wn_wb;
        int rw_ex, rw_mem, rw_wb, memread, branch;
        int e_pc, e_ifid_en, e_flush, e_idex, e_exmem, e_fa, e_fb;
        int n_pc, n_fa;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic clear_in();
        rs_id = '0; rt_id = '0; rs_ex = '0; rt_ex = '0;
        wn_ex = '0; wn_mem = '0; wn_wb = '0;
        uses_rs_id = 1'b0; uses_rt_id = 1'b0; jump_id = 1'b0;
        regwrite_ex = 1'b0; regwrite_mem = 1'b0; regwrite_wb = 1'b0;
        memread_ex = 1'b0; mul_ex = 1'b0; branch_taken_mem = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        rs_id = 5'(v.rs_id); rt_id = 5'(v.rt_id);
        uses_rs_id = 1'(v.uses_rs); uses_rt_id = 1'(v.uses_rt); jump_id = 1'(v.jump);
        rs_ex = 5'(v.rs_ex); rt_ex = 5'(v.rt_ex);
        wn_ex = 5'(v.wn_ex); wn_mem = 5'(v.wn_mem); wn_wb = 5'(v.wn_wb);
        regwrite_ex = 1'(v.rw_ex); regwrite_mem = 1'(v.rw_mem); regwrite_wb = 1'(v.rw_wb);
        memread_ex = 1'(v.memread); branch_taken_mem = 1'(v.branch);
        mul_ex = 1'b0;
    endtask

    // This task returns at a falling edge, with reset released and all inputs idle.
    task automatic do_reset();
        clear_in();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // Fields: rs_id rt_id uses_rs uses_rt jump | rs_ex rt_ex wn_ex wn_mem wn_wb |
        //         rw_ex rw_mem rw_wb memread branch | pc ifid_en flush idex exmem fa fb | n_pc n_fa
        vecs[0]  = '{0,0,0,0,0, 0,0,0,0,0,   0,0,0,0,0, 1,1,0,0,0,2'b00,2'b00, 1,2'b00};
        vecs[1]  = '{0,0,0,0,0, 7,0,0,7,7,   0,1,1,0,0, 1,1,0,0,0,2'b10,2'b00, 1,2'b00};
        vecs[2]  = '{0,0,0,0,0, 0,0,0,0,0,   0,1,1,0,0, 1,1,0,0,0,2'b00,2'b00, 1,2'b00};
        vecs[3]  = '{0,0,0,0,0, 3,3,0,4,3,   0,1,1,0,0, 1,1,0,0,0,2'b01,2'b01, 1,2'b00};
        vecs[4]  = '{0,0,0,0,0, 2,9,0,9,2,   0,1,1,0,0, 1,1,0,0,0,2'b01,2'b10, 1,2'b00};
        vecs[5]  = '{0,0,0,0,0, 6,0,0,6,6,   0,0,1,0,0, 1,1,0,0,0,2'b01,2'b00, 1,2'b00};
        vecs[6]  = '{5,0,1,0,0, 0,0,5,0,0,   1,0,0,1,0, 0,0,0,1,0,2'b00,2'b00, 0,2'b00};
        vecs[7]  = '{1,5,1,0,0, 0,0,5,0,0,   1,0,0,1,0, 1,1,0,0,0,2'b00,2'b00, 1,2'b00};
        vecs[8]  = '{1,5,1,1,0, 0,0,5,0,0,   1,0,0,1,0, 0,0,0,1,0,2'b00,2'b00, 0,2'b00};
        vecs[9]  = '{5,0,1,0,0, 0,0,5,0,0,   1,0,0,0,0, 1,1,0,0,0,2'b00,2'b00, 0,2'b00};
        vecs[10] = '{0,0,1,0,0, 0,0,0,0,0,   1,0,0,1,0, 1,1,0,0,0,2'b00,2'b00, 1,2'b00};
        vecs[11] = '{0,0,0,0,1, 0,0,0,0,0,   0,0,0,0,0, 1,1,1,0,0,2'b00,2'b00, 1,2'b00};
        vecs[12] = '{5,0,1,0,1, 0,0,5,0,0,   1,0,0,1,0, 0,0,0,1,0,2'b00,2'b00, 0,2'b00};
        vecs[13] = '{5,0,1,0,1, 0,0,5,0,0,   1,0,0,1,1, 1,1,1,1,1,2'b00,2'b00, 1,2'b00};
        vecs[14] = '{0,12,0,1,0, 0,12,0,0,12, 0,0,1,0,0, 1,1,0,0,0,2'b00,2'b01, 0,2'b00};
        vecs[15] = '{3,0,1,0,0, 3,0,0,3,0,   0,1,0,0,0, 1,1,0,0,0,2'b10,2'b00, 0,2'b00};

        // Reset state. Hazard inputs are present, but the outputs must stay forced.
        clear_in();
        rs_id = 5'd5; uses_rs_id = 1'b1; wn_ex = 5'd5; regwrite_ex = 1'b1; memread_ex = 1'b1;
        rs_ex = 5'd5; wn_mem = 5'd5; regwrite_mem = 1'b1; mul_ex = 1'b1;
        #12;
        check("rst_outputs", {m_pc_en, m_ifid_en, m_ifid_flush, m_idex_bubble, m_exmem_bubble,
                              m_fwd_a, m_fwd_b, m_mul_busy}, 10'b1100000000);
        check("rst_counters", {m_stall_cnt, m_flush_cnt}, 32'h0);
        do_reset();
        #1;
        check("post_rst_counters", {m_stall_cnt, m_flush_cnt}, 32'h0);

        // Combinational table. mul_ex stays 0 so both FSMs remain in RUN.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            apply_vec(vecs[i]);
            #1;
            check($sformatf("vec%0d_fwd", i),
                  {m_pc_en, m_ifid_en, m_ifid_flush, m_idex_bubble, m_exmem_bubble, m_fwd_a, m_fwd_b},
                  {1'(vecs[i].e_pc), 1'(vecs[i].e_ifid_en), 1'(vecs[i].e_flush),
                   1'(vecs[i].e_idex), 1'(vecs[i].e_exmem), 2'(vecs[i].e_fa), 2'(vecs[i].e_fb)});
            check($sformatf("vec%0d_nofwd", i), {n_pc_en, n_fwd_a, n_fwd_b},
                  {1'(vecs[i].n_pc), 2'(vecs[i].n_fa), 2'b00});
        end

        // Load-use: a single stall cycle, then WB forwarding once the add reaches EX.
        do_reset();
        rs_id = 5'd5; uses_rs_id = 1'b1; wn_ex = 5'd5; regwrite_ex = 1'b1; memread_ex = 1'b1;
        #1;
        check("lu_stall", {m_pc_en, m_ifid_en, m_idex_bubble}, 3'b001);
        @(negedge clk);
        wn_ex = '0; regwrite_ex = 1'b0; memread_ex = 1'b0; wn_mem = 5'd5; regwrite_mem = 1'b1;
        #1;
        check("lu_release", {m_pc_en, m_idex_bubble}, 2'b10);
        check("lu_stall_cnt", m_stall_cnt, 32'd1);
        @(negedge clk);
        clear_in();
        rs_ex = 5'd5; wn_wb = 5'd5; regwrite_wb = 1'b1;
        #1;
        check("lu_fwd_a", m_fwd_a, 2'b01);

        // Multiply: 3 hold cycles with MUL_LATENCY=4, and none with MUL_LATENCY=1.
        do_reset();
        mul_ex = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("mul4_c%0d", c), {m_mul_busy, m_exmem_bubble, m_pc_en, m_ifid_en},
                  (c < 3) ? 4'b1100 : 4'b0011);
            check($sformatf("mul1_c%0d", c), {s_mul_busy, s_exmem_bubble, s_pc_en}, 3'b001);
            @(negedge clk);
        end
        mul_ex = 1'b0;
        #1;
        check("mul4_stall_cnt", m_stall_cnt, 32'd3);
        check("mul1_stall_cnt", s_stall_cnt, 32'd0);

        // A branch in the second hold cycle aborts the multiply.
        do_reset();
        mul_ex = 1'b1;
        @(negedge clk);
        branch_taken_mem = 1'b1;
        #1;
        check("br_outputs", {m_ifid_flush, m_idex_bubble, m_exmem_bubble, m_pc_en}, 4'b1111);
        @(negedge clk);
        clear_in();
        #1;
        check("br_after", {m_mul_busy, m_pc_en}, 2'b01);
        check("br_flush_cnt", m_flush_cnt, 32'd1);
        check("br_stall_cnt", m_stall_cnt, 32'd1);

        // No forwarding: the producer is in MEM, then WB, and the stall lifts once it has retired.
        do_reset();
        rs_id = 5'd3; uses_rs_id = 1'b1; rs_ex = 5'd3; rt_ex = 5'd3;
        wn_mem = 5'd3; regwrite_mem = 1'b1;
        #1;
        check("nf_c0", {n_pc_en, n_idex_bubble, n_fwd_a, n_fwd_b}, 6'b010000);
        check("nf_c0_main_fwd", m_fwd_a, 2'b10);
        @(negedge clk);
        wn_mem = '0; regwrite_mem = 1'b0; wn_wb = 5'd3; regwrite_wb = 1'b1;
        #1;
        check("nf_c1", {n_pc_en, n_idex_bubble, n_fwd_a, n_fwd_b}, 6'b010000);
        @(negedge clk);
        wn_wb = '0; regwrite_wb = 1'b0;
        #1;
        check("nf_c2", {n_pc_en, n_idex_bubble, n_fwd_a, n_fwd_b}, 6'b100000);
        check("nf_stall_cnt", n_stall_cnt, 32'd2);

        // Asynchronous reset between edges during MUL_WAIT.
        do_reset();
        mul_ex = 1'b1;
        @(negedge clk);
        #1;
        check("ar_busy_before", m_mul_busy, 32'd1);
        check("ar_stall_before", m_stall_cnt, 32'd1);
        #1;
        rst = 1'b0;
        rs_id = 5'd5; uses_rs_id = 1'b1; wn_ex = 5'd5; regwrite_ex = 1'b1; memread_ex = 1'b1;
        #1;
        check("ar_outputs", {m_mul_busy, m_pc_en, m_idex_bubble, m_exmem_bubble}, 4'b0100);
        check("ar_counters", {m_stall_cnt, m_flush_cnt}, 32'h0);
        @(negedge clk);
        clear_in();
        rst = 1'b1;
        mul_ex = 1'b1;
        #1;
        check("ar_restart_run", m_mul_busy, 32'd1);
        @(negedge clk);
        #1;
        check("ar_restart_wait", m_mul_busy, 32'd1);
        clear_in();

        // Saturation of the 2-bit counters.
        do_reset();
        rs_id = 5'd3; uses_rs_id = 1'b1; wn_wb = 5'd3; regwrite_wb = 1'b1;
        repeat (5) @(negedge clk);
        clear_in();
        branch_taken_mem = 1'b1;
        repeat (5) @(negedge clk);
        branch_taken_mem = 1'b0;
        #1;
        check("sat_stall_cnt", n_stall_cnt, 32'd3);
        check("sat_flush_cnt", n_flush_cnt, 32'd3);
        check("main_flush_cnt5", m_flush_cnt, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
